// File: rtl/renkon_pkg.sv
// ---------------------------------------------------------------------------
// renkon_pkg
//   Shared constants and types for the renkon output stage.
//
//   RENKON_CORE     number of cores feeding the output mux
//   RENKON_CORELOG  log2(RENKON_CORE); core select is RENKON_CORELOG+1 bits
//                   so that 0 can mean "idle / drive zero"
//   DWIDTH          output data width carried by the mux
//   SIZEWIDTH       width of the per-core output pixel count
//   MEMWIDTH        output memory address width
// ---------------------------------------------------------------------------
package renkon_pkg;

  localparam int RENKON_CORE    = 8;
  localparam int RENKON_CORELOG = 3;
  localparam int DWIDTH         = 16;
  localparam int SIZEWIDTH      = 16;
  localparam int MEMWIDTH       = 16;

  // Select width: one extra bit so RENKON_CORE itself is representable
  // (select k addresses core k-1, select 0 means no core).
  localparam int SEL_W = RENKON_CORELOG + 1;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [SIZEWIDTH-1:0] size_t;
  typedef logic [MEMWIDTH-1:0]  addr_t;

  // Write-back sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FIN,
    DONE
  } renkon_out_state_t;

  // Requests for more cores than physically exist drain only the real ones.
  function automatic sel_t clamp_cores(input sel_t cores);
    return (cores > sel_t'(RENKON_CORE)) ? sel_t'(RENKON_CORE) : cores;
  endfunction

endpackage

// File: rtl/renkon_ctrl_output_if.sv
// ---------------------------------------------------------------------------
// renkon_ctrl_output_if
//   Bundle between the renkon top-level FSM / output mux / output memory and
//   the write-back sequencer.
//
//   start         1-cycle request to begin write-back (honoured in IDLE only)
//   out_size      pixels per core (N), latched on accepted start
//   active_cores  cores to drain (C), latched on accepted start
//   base_addr     output memory base, latched on accepted start
//   stall         downstream back-pressure; blocks issue of new selects
//   output_re     core select into the registered output mux (0 = idle)
//   mem_we        output memory write enable (data = mux output same cycle)
//   mem_addr      output memory write address
//   busy          high from the first cycle after an accepted start through
//                 the done cycle
//   done          one-cycle completion pulse
//
//   master: the environment driving requests (top FSM + downstream)
//   slave : the sequencer itself
// ---------------------------------------------------------------------------
interface renkon_ctrl_output_if
  import renkon_pkg::*;
();

  logic  start;
  size_t out_size;
  sel_t  active_cores;
  addr_t base_addr;
  logic  stall;

  sel_t  output_re;
  logic  mem_we;
  addr_t mem_addr;
  logic  busy;
  logic  done;

  modport master (
    output start,
    output out_size,
    output active_cores,
    output base_addr,
    output stall,
    input  output_re,
    input  mem_we,
    input  mem_addr,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  out_size,
    input  active_cores,
    input  base_addr,
    input  stall,
    output output_re,
    output mem_we,
    output mem_addr,
    output busy,
    output done
  );

endinterface

// File: rtl/renkon_ctrl_output_addr.sv
// ---------------------------------------------------------------------------
// renkon_ctrl_output_addr
//   Incremental address generator for the write-back walk. The element for
//   core c, pixel p lives at base + c*N + p (mod 2^MEMWIDTH). Instead of a
//   multiplier it keeps a row pointer (base + c*N) that steps by N per core,
//   and a pixel offset p that bumps once the core index wraps.
//
//   clk, rst     clock, synchronous active-high reset
//   init         load base and N, point at element (0,0)
//   base, size   base address and per-core pixel count (N), used on init
//   step         move to the next core of the same pixel
//   next_pixel   wrap back to core 0 and advance to the next pixel
//   addr         address of the current element (combinational)
// ---------------------------------------------------------------------------
module renkon_ctrl_output_addr
  import renkon_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  init,
  input  addr_t base,
  input  size_t size,
  input  logic  step,
  input  logic  next_pixel,
  output addr_t addr
);

  addr_t base_q;
  addr_t stride_q;
  addr_t row_q;
  addr_t pix_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      stride_q <= '0;
      row_q    <= '0;
      pix_q    <= '0;
    end else if (init) begin
      base_q   <= base;
      stride_q <= addr_t'(size);
      row_q    <= base;
      pix_q    <= '0;
    end else if (next_pixel) begin
      row_q    <= base_q;
      pix_q    <= pix_q + addr_t'(1);
    end else if (step) begin
      row_q    <= row_q + stride_q;
    end
  end

  // Both sums wrap naturally at MEMWIDTH bits.
  assign addr = row_q + pix_q;

endmodule

// File: rtl/renkon_ctrl_output.sv
// ---------------------------------------------------------------------------
// renkon_ctrl_output
//   Write-back sequencer for the renkon output stage. After a layer finishes
//   it walks pixel p = 0..N-1 (outer) and core c = 0..C-1 (inner), driving
//   the core select output_re = c+1 into the registered output mux on every
//   non-stalled cycle. Because the mux adds one register stage, the memory
//   write enable and address are delayed by one cycle so they line up with
//   the mux data.
//
//   clk   clock, rising edge
//   rst   synchronous active-high reset; aborts a run with no done pulse
//   bus   renkon_ctrl_output_if.slave (start/size/cores/base/stall in,
//         output_re/mem_we/mem_addr/busy/done out)
//
//   Timing for a start seen in cycle s with S stalled cycles:
//     selects in cycles s+1 .. s+N*C+S, last write one cycle later (FIN),
//     done in cycle s+N*C+S+2. An empty request (N=0 or C=0) goes straight
//     to FIN, so done lands in cycle s+2 with no writes.
// ---------------------------------------------------------------------------
module renkon_ctrl_output
  import renkon_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  renkon_ctrl_output_if.slave   bus
);

  renkon_out_state_t state_q, state_d;

  sel_t  core_q;      // current core index c
  sel_t  cores_q;     // clamped core count C
  size_t pix_q;       // current pixel index p
  size_t size_q;      // pixel count N

  sel_t  sel;
  logic  accept;
  logic  empty_req;
  logic  issue;
  logic  core_wrap;
  logic  last_elem;
  addr_t elem_addr;

  logic  we_q;
  addr_t addr_q;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign accept    = (state_q == IDLE) && bus.start;
  assign empty_req = (clamp_cores(bus.active_cores) == '0) || (bus.out_size == '0);

  // Only meaningful in ISSUE, where cores_q and size_q are both non-zero.
  assign core_wrap = (core_q == cores_q - sel_t'(1));
  assign last_elem = core_wrap && (pix_q == size_q - size_t'(1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and select
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sel     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = empty_req ? FIN : ISSUE;
      end
      ISSUE: begin
        // A stalled cycle issues nothing and holds (c,p).
        if (!bus.stall) begin
          sel = core_q + sel_t'(1);
          if (last_elem) state_d = FIN;
        end
      end
      FIN:     state_d = DONE;   // the last write drains through the mux
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue = (sel != '0);

  // -------------------------------------------------------------------------
  // Walk counters: core is the inner loop, pixel the outer one
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      core_q  <= '0;
      cores_q <= '0;
      pix_q   <= '0;
      size_q  <= '0;
    end else if (accept) begin
      core_q  <= '0;
      cores_q <= clamp_cores(bus.active_cores);
      pix_q   <= '0;
      size_q  <= bus.out_size;
    end else if (issue) begin
      if (core_wrap) begin
        core_q <= '0;
        pix_q  <= pix_q + size_t'(1);
      end else begin
        core_q <= core_q + sel_t'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Address generator for the element currently being selected
  // -------------------------------------------------------------------------
  renkon_ctrl_output_addr u_addr (
    .clk        (clk),
    .rst        (rst),
    .init       (accept),
    .base       (bus.base_addr),
    .size       (bus.out_size),
    .step       (issue && !core_wrap),
    .next_pixel (issue && core_wrap),
    .addr       (elem_addr)
  );

  // -------------------------------------------------------------------------
  // Write port, one stage behind the select to match the mux register.
  // The write of an issued element always follows, whatever stall does next.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q <= issue;
      if (issue) addr_q <= elem_addr;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.output_re = sel;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_renkon_ctrl_output.sv
// ---------------------------------------------------------------------------
// tb_renkon_ctrl_output
//   Self-checking bench for the renkon write-back sequencer. A reference
//   model tracks each run as "element k of N*C", derives the expected select,
//   write and address from k with plain arithmetic, and is compared with the
//   DUT on every falling edge. Directed runs additionally pin literal
//   addresses, write counts and done latencies.
// ---------------------------------------------------------------------------
module tb_renkon_ctrl_output;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  renkon_ctrl_output_if bus ();

  renkon_ctrl_output dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic [15:0] writes[$];
  bit          seen_done;
  int          done_cyc;
  int          start_cyc;
  int          first_re_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Reference model: a run is N*C elements numbered k; element k is core
  // k%C, pixel k/C. After the last element there is one drain cycle and one
  // done cycle.
  // -------------------------------------------------------------------------
  bit          m_run     = 1'b0;
  int          m_k, m_total, m_n, m_c, m_post;
  logic [15:0] m_base;
  bit          m_prev_we = 1'b0;
  logic [15:0] m_prev_addr;

  always @(negedge clk) begin
    int exp_re;
    if (chk_en) begin
      exp_re = (m_run && m_k < m_total && !bus.stall) ? (m_k % m_c) + 1 : 0;

      check("output_re", 64'(bus.output_re), 64'(exp_re));
      check("mem_we",    64'(bus.mem_we),    64'(m_prev_we));
      if (m_prev_we) check("mem_addr", 64'(bus.mem_addr), 64'(m_prev_addr));
      check("busy",      64'(bus.busy),      64'(m_run));
      check("done",      64'(bus.done),      64'(m_run && m_k >= m_total && m_post == 1));

      if (bus.mem_we === 1'b1) writes.push_back(bus.mem_addr);
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
      if (bus.output_re != 0 && first_re_cyc < 0) first_re_cyc = cyc;

      // Advance to what the coming clock edge should produce.
      if (rst) begin
        m_run     = 1'b0;
        m_prev_we = 1'b0;
      end else begin
        m_prev_we = (exp_re != 0);
        if (exp_re != 0)
          m_prev_addr = 16'(int'(m_base) + (m_k % m_c) * m_n + m_k / m_c);
        if (m_run) begin
          if (m_k >= m_total) begin
            if (m_post == 1) m_run = 1'b0;
            else             m_post++;
          end else if (exp_re != 0) begin
            m_k++;
          end
        end else if (bus.start) begin
          m_run        = 1'b1;
          m_k          = 0;
          m_post       = 0;
          m_n          = int'(bus.out_size);
          m_c          = (bus.active_cores > 8) ? 8 : int'(bus.active_cores);
          m_base       = bus.base_addr;
          m_total      = m_n * m_c;
          start_cyc    = cyc;
          first_re_cyc = -1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // One run: start in a single cycle, then per-cycle stall from a fixed window
  // plus a random percentage; optional stray start pulses while issuing.
  task automatic run_op(input int n, input int c, input logic [15:0] base,
                        input int stall_pct, input int stall_from, input int stall_len,
                        input bit stray);
    @(posedge clk); #1;
    writes.delete();
    seen_done         = 1'b0;
    bus.out_size      = 16'(n);
    bus.active_cores  = 4'(c);
    bus.base_addr     = base;
    bus.stall         = 1'b0;
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2000 && !seen_done; i++) begin
      bus.stall = ((i >= stall_from) && (i < stall_from + stall_len)) ||
                  (int'($urandom_range(99)) < stall_pct);
      bus.start = stray && m_run && (m_k < m_total) && ($urandom_range(3) == 0);
      // Stray start also carries different parameters, which must be ignored.
      if (bus.start) begin
        bus.out_size     = 16'($urandom_range(9));
        bus.active_cores = 4'($urandom_range(15));
        bus.base_addr    = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("done_seen", 64'(seen_done), 64'(1));
  endtask

  // Write count must be N*min(C,8) and every address distinct.
  task automatic check_writes(input int n, input int c);
    bit seen[logic [15:0]];
    int dups = 0;
    int cc   = (c > 8) ? 8 : c;
    foreach (writes[i]) begin
      if (seen.exists(writes[i])) dups++;
      seen[writes[i]] = 1'b1;
    end
    check("write_count", 64'(writes.size()), 64'(n * cc));
    check("dup_addr",    64'(dups),          64'(0));
  endtask

  task automatic check_addr_list(input string name, input logic [15:0] exp[$]);
    check({name, "_len"}, 64'(writes.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < writes.size()) check(name, 64'(writes[i]), 64'(exp[i]));
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [15:0] exp_list[$];

    bus.start        = 1'b0;
    bus.out_size     = '0;
    bus.active_cores = '0;
    bus.base_addr    = '0;
    bus.stall        = 1'b0;
    seen_done        = 1'b0;
    first_re_cyc     = -1;

    // Reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("rst_output_re", 64'(bus.output_re), 64'(0));
    check("rst_mem_we",    64'(bus.mem_we),    64'(0));
    check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // N=3, C=2, base 0x100, no stall
    run_op(3, 2, 16'h0100, 0, 0, 0, 1'b0);
    exp_list = '{16'h0100, 16'h0103, 16'h0101, 16'h0104, 16'h0102, 16'h0105};
    check_addr_list("t1_addr", exp_list);
    check("t1_first_re", 64'(first_re_cyc - start_cyc), 64'(1));
    check("t1_done_lat", 64'(done_cyc - start_cyc),     64'(8));

    // N=4, C=8, stall for 3 cycles mid-run
    run_op(4, 8, 16'h2000, 0, 5, 3, 1'b0);
    check_writes(4, 8);
    check("t2_done_lat", 64'(done_cyc - start_cyc), 64'(4 * 8 + 3 + 2));

    // C=12 clamps to 8, N=1: addresses base..base+7
    run_op(1, 12, 16'h0040, 0, 0, 0, 1'b0);
    exp_list = '{16'h0040, 16'h0041, 16'h0042, 16'h0043,
                 16'h0044, 16'h0045, 16'h0046, 16'h0047};
    check_addr_list("t3_addr", exp_list);
    check("t3_done_lat", 64'(done_cyc - start_cyc), 64'(10));

    // Empty requests
    run_op(0, 4, 16'h0300, 0, 0, 0, 1'b0);
    check("t4a_writes",   64'(writes.size()),       64'(0));
    check("t4a_done_lat", 64'(done_cyc - start_cyc), 64'(2));
    run_op(5, 0, 16'h0300, 0, 0, 0, 1'b0);
    check("t4b_writes",   64'(writes.size()),       64'(0));
    check("t4b_done_lat", 64'(done_cyc - start_cyc), 64'(2));

    // Address wrap
    run_op(2, 2, 16'hFFFE, 0, 0, 0, 1'b0);
    exp_list = '{16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001};
    check_addr_list("t5_addr", exp_list);

    // Reset three cycles into a run
    @(posedge clk); #1;
    seen_done        = 1'b0;
    bus.out_size     = 16'd4;
    bus.active_cores = 4'd8;
    bus.base_addr    = 16'h0500;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_output_re", 64'(bus.output_re), 64'(0));
    check("abort_mem_we",    64'(bus.mem_we),    64'(0));
    check("abort_busy",      64'(bus.busy),      64'(0));
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(seen_done), 64'(0));

    // Fresh run after the abort, with stray starts while busy
    run_op(3, 5, 16'h0600, 0, 0, 0, 1'b1);
    check_writes(3, 5);
    check("t6_done_lat", 64'(done_cyc - start_cyc), 64'(3 * 5 + 2));

    // Randomized runs with random stalls and stray starts
    for (int r = 0; r < 24; r++) begin
      int n = $urandom_range(6);
      int c = $urandom_range(12);
      run_op(n, c, 16'($urandom), 30, 0, 0, 1'b1);
      check_writes(n, c);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
